// File: rtl/cluster_periph_initiator.sv
// Initiator end of the cluster peripheral bus.
// A valid/ready command stream is issued as per_req/per_gnt transactions.
// The in-order bus responses come back on a valid/ready response stream.
// Optional feature macro: PERIPH_INIT_TIMEOUT_EN adds a response timeout that
// pushes a 32'hDEAD_BEEF error response for any transfer left unanswered.
module cluster_periph_initiator #(
  parameter int unsigned ID_WIDTH       = 5,
  parameter int unsigned ID_VALUE       = 0,
  parameter int unsigned MAX_OUTST      = 4
`ifdef PERIPH_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic                cmd_wen_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                per_req_o,
  output logic [31:0]         per_add_o,
  output logic                per_wen_o,
  output logic [31:0]         per_wdata_o,
  output logic [3:0]          per_be_o,
  output logic [ID_WIDTH-1:0] per_id_o,
  input  logic                per_gnt_i,
  input  logic                per_r_valid_i,
  input  logic                per_r_opc_i,
  input  logic [ID_WIDTH-1:0] per_r_id_i,
  input  logic [31:0]         per_r_rdata_i,
  output logic                busy_o,
  output logic                spurious_o,
  output logic                timeout_o
);

  localparam int unsigned OccW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [ID_WIDTH-1:0] IdVal = ID_WIDTH'(ID_VALUE);
  localparam logic [OccW-1:0] OccMax = OccW'(MAX_OUTST);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTST - 1);

  // Request stage
  logic        req_vld_q, req_vld_d;
  logic [31:0] req_add_q, req_add_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;

  // Credit and in-flight tracking
  logic [OccW-1:0] occ_q, occ_d;
  logic [OccW-1:0] infl_q, infl_d;

  // Response FIFO, entries are {rdata, err}
  logic [32:0]     fifo_q [MAX_OUTST];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] cnt_q, cnt_d;

  logic        spur_q, spur_d;
  logic        accept, gnt_fire, rsp_hit, pop, push, tmo_hit;
  logic [32:0] push_data;

  // Handshake decode; the ready is held low while reset is asserted
  always_comb begin
    cmd_ready_o = !rst_i && (!req_vld_q || per_gnt_i) && (occ_q < OccMax);
    accept      = cmd_valid_i && cmd_ready_o;
    gnt_fire    = req_vld_q && per_gnt_i;
    rsp_hit     = per_r_valid_i && (infl_q != '0) && (per_r_id_i == IdVal);
    pop         = rsp_valid_o && rsp_ready_i;
    push        = rsp_hit || tmo_hit;
    push_data   = tmo_hit ? {32'hDEAD_BEEF, 1'b1} : {per_r_rdata_i, per_r_opc_i};
  end

`ifdef PERIPH_INIT_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_flag_q, tmo_flag_d;

  // Timeout counter runs only while something is outstanding and unanswered
  always_comb begin
    tmo_hit    = 1'b0;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    if ((infl_q == '0) || rsp_hit) begin
      tmo_d = '0;
    end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
      tmo_hit    = 1'b1;
      tmo_d      = '0;
      tmo_flag_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // Timeout state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign timeout_o = tmo_flag_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state for request stage, counters, FIFO pointers and sticky flag
  always_comb begin
    req_vld_d   = req_vld_q;
    req_add_d   = req_add_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    if (accept) begin
      req_vld_d   = 1'b1;
      req_add_d   = cmd_addr_i;
      req_wen_d   = cmd_wen_i;
      req_wdata_d = cmd_wdata_i;
      req_be_d    = cmd_be_i;
    end else if (gnt_fire) begin
      req_vld_d = 1'b0;
    end

    occ_d = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!accept && pop) begin
      occ_d = occ_q - OccW'(1);
    end

    infl_d = infl_q;
    if (gnt_fire && !push) begin
      infl_d = infl_q + OccW'(1);
    end else if (!gnt_fire && push) begin
      infl_d = infl_q - OccW'(1);
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + OccW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - OccW'(1);
    end

    spur_d = spur_q || (per_r_valid_i && !rsp_hit);
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_vld_q   <= 1'b0;
      req_add_q   <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      occ_q       <= '0;
      infl_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      spur_q      <= 1'b0;
    end else begin
      req_vld_q   <= req_vld_d;
      req_add_q   <= req_add_d;
      req_wen_q   <= req_wen_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      spur_q      <= spur_d;
    end
  end

  // FIFO storage; credits guarantee a push never lands on a full FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  // Output mapping
  always_comb begin
    per_req_o   = req_vld_q;
    per_add_o   = req_add_q;
    per_wen_o   = req_wen_q;
    per_wdata_o = req_wdata_q;
    per_be_o    = req_be_q;
    per_id_o    = IdVal;
    rsp_valid_o = (cnt_q != '0);
    rsp_rdata_o = fifo_q[rd_ptr_q][32:1];
    rsp_err_o   = fifo_q[rd_ptr_q][0];
    busy_o      = (occ_q != '0);
    spurious_o  = spur_q;
  end

endmodule

// File: tb/tb_cluster_periph_initiator.sv
// Directed testbench for cluster_periph_initiator (default parameters).
// Define PERIPH_INIT_TIMEOUT_EN to build with an 8-cycle timeout and run its test.
module tb_cluster_periph_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wen;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        per_req, per_wen, per_gnt, per_r_valid, per_r_opc;
  logic [31:0] per_add, per_wdata, per_r_rdata;
  logic [3:0]  per_be;
  logic [4:0]  per_id, per_r_id;
  logic        busy, spurious, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cluster_periph_initiator #(
    .ID_WIDTH      (5),
    .ID_VALUE      (0),
    .MAX_OUTST     (4)
`ifdef PERIPH_INIT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_wen_i    (cmd_wen),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_be_i     (cmd_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .per_req_o    (per_req),
    .per_add_o    (per_add),
    .per_wen_o    (per_wen),
    .per_wdata_o  (per_wdata),
    .per_be_o     (per_be),
    .per_id_o     (per_id),
    .per_gnt_i    (per_gnt),
    .per_r_valid_i(per_r_valid),
    .per_r_opc_i  (per_r_opc),
    .per_r_id_i   (per_r_id),
    .per_r_rdata_i(per_r_rdata),
    .busy_o       (busy),
    .spurious_o   (spurious),
    .timeout_o    (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_wen     = 1'b0;
    cmd_wdata   = '0;
    cmd_be      = '0;
    rsp_ready   = 1'b0;
    per_gnt     = 1'b0;
    per_r_valid = 1'b0;
    per_r_opc   = 1'b0;
    per_r_id    = '0;
    per_r_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({per_req, rsp_valid, busy, spurious, timeout, cmd_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {per_req, rsp_valid, busy, spurious, timeout, cmd_ready});
    end
    checks++;
    if (per_id !== 5'd0 || per_add !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_fields id=%h add=%h rdata=%h want 0", per_id, per_add, rsp_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h1020_0400;
    cmd_wen   = 1'b1;
    cmd_be    = 4'hF;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_cmd_ready got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    for (int c = 0; c < 3; c++) begin
      per_gnt = (c == 2);
      #1;
      checks++;
      if (per_req !== 1'b1 || per_add !== 32'h1020_0400 || per_wen !== 1'b1 ||
          per_be !== 4'hF || busy !== 1'b1) begin
        errors++;
        $display("FAIL rd_req_hold c=%0d req=%b add=%h wen=%b be=%h busy=%b want 1 10200400 1 f 1",
                 c, per_req, per_add, per_wen, per_be, busy);
      end
      tick();
    end
    per_gnt     = 1'b0;
    per_r_valid = 1'b1;
    per_r_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if (per_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_gnt req=%b rsp_valid=%b want 0 0", per_req, rsp_valid);
    end
    tick();
    per_r_valid = 1'b0;
    rsp_ready   = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp valid=%b rdata=%h err=%b want 1 cafe0001 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL rd_done valid=%b busy=%b spurious=%b want 0 0 0", rsp_valid, busy, spurious);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      cmd_valid   = (c < 4);
      cmd_addr    = 32'h1000_0000 + 32'(4 * c);
      cmd_wen     = 1'b0;
      cmd_wdata   = 32'h5A00_0000 + 32'(c);
      cmd_be      = 4'hF;
      per_gnt     = 1'b1;
      per_r_valid = (c >= 2 && c <= 5);
      per_r_rdata = 32'h0000_B000 + 32'(c - 2);
      rsp_ready   = 1'b1;
      #1;
      if (c < 4) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready c=%0d got %b want 1", c, cmd_ready);
        end
      end
      checks++;
      if (per_req !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL b2b_req c=%0d got %b want %b", c, per_req, (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (per_add !== 32'h1000_0000 + 32'(4 * (c - 1)) || per_wen !== 1'b0 ||
            per_wdata !== 32'h5A00_0000 + 32'(c - 1)) begin
          errors++;
          $display("FAIL b2b_fields c=%0d add=%h wen=%b wdata=%h", c, per_add, per_wen, per_wdata);
        end
      end
      checks++;
      if (rsp_valid !== (c >= 3)) begin
        errors++;
        $display("FAIL b2b_rsp_valid c=%0d got %b want %b", c, rsp_valid, (c >= 3));
      end
      if (c >= 3) begin
        checks++;
        if (rsp_rdata !== 32'h0000_B000 + 32'(c - 3) || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rsp_data c=%0d got %h/%b want %h/0", c, rsp_rdata, rsp_err,
                   32'h0000_B000 + 32'(c - 3));
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || per_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done busy=%b valid=%b req=%b want 0 0 0", busy, rsp_valid, per_req);
    end
  endtask

  task automatic test_credit_stall();
    cmd_addr = 32'h2000_0000;
    cmd_wen  = 1'b1;
    cmd_be   = 4'hF;
    for (int c = 0; c < 8; c++) begin
      cmd_valid   = 1'b1;
      per_gnt     = 1'b1;
      per_r_valid = (c >= 2 && c <= 5);
      per_r_rdata = 32'h0000_D000 + 32'(c - 2);
      rsp_ready   = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== (c < 4)) begin
        errors++;
        $display("FAIL stall_ready c=%0d got %b want %b", c, cmd_ready, (c < 4));
      end
      tick();
    end
    per_r_valid = 1'b0;
    rsp_ready   = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_D000 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_pop valid=%b rdata=%h ready=%b want 1 0000d000 0",
               rsp_valid, rsp_rdata, cmd_ready);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_one_credit got %b want 1", cmd_ready);
    end
    tick();
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || per_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_refull ready=%b req=%b want 0 1", cmd_ready, per_req);
    end
    tick();
    cmd_valid   = 1'b0;
    per_r_valid = 1'b1;
    per_r_rdata = 32'h0000_D004;
    tick();
    per_r_valid = 1'b0;
    rsp_ready   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_D000 + 32'(k)) begin
        errors++;
        $display("FAIL stall_drain k=%0d valid=%b rdata=%h want 1 %h", k, rsp_valid, rsp_rdata,
                 32'h0000_D000 + 32'(k));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done busy=%b valid=%b want 0 0", busy, rsp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    per_r_valid = 1'b1;
    per_r_rdata = 32'h1111_1111;
    tick();
    per_r_valid = 1'b0;
    #1;
    checks++;
    if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle spurious=%b valid=%b want 1 0", spurious, rsp_valid);
    end
    do_reset();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h3000_0010;
    cmd_wen   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    per_gnt   = 1'b1;
    tick();
    per_gnt     = 1'b0;
    per_r_valid = 1'b1;
    per_r_id    = 5'd1;
    per_r_rdata = 32'h2222_2222;
    tick();
    per_r_valid = 1'b0;
    per_r_id    = 5'd0;
    #1;
    checks++;
    if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_id spurious=%b valid=%b want 1 0", spurious, rsp_valid);
    end
    per_r_valid = 1'b1;
    per_r_opc   = 1'b1;
    per_r_rdata = 32'h3333_3333;
    tick();
    per_r_valid = 1'b0;
    per_r_opc   = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3333_3333 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL spur_real valid=%b rdata=%h err=%b want 1 33333333 1",
               rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    cmd_wen = 1'b1;
    cmd_be  = 4'hF;
    for (int c = 0; c < 3; c++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 32'h4000_0000 + 32'(4 * c);
      per_gnt   = (c >= 1);
      tick();
    end
    cmd_valid = 1'b0;
    per_gnt   = 1'b0;
    #1;
    checks++;
    if (per_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup req=%b busy=%b want 1 1", per_req, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({per_req, rsp_valid, busy, spurious, timeout, cmd_ready} !== 6'b0 ||
        per_add !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset flags=%b add=%h want 000000 0",
               {per_req, rsp_valid, busy, spurious, timeout, cmd_ready}, per_add);
    end
    tick();
    rst = 1'b0;
    tick();
    per_r_valid = 1'b1;
    per_r_rdata = 32'h4444_4444;
    tick();
    per_r_valid = 1'b0;
    #1;
    checks++;
    if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_late spurious=%b valid=%b want 1 0", spurious, rsp_valid);
    end
    idle_inputs();
  endtask

`ifdef PERIPH_INIT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h5000_0000;
    cmd_wen   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    per_gnt   = 1'b1;
    tick();
    per_gnt = 1'b0;
    for (int c = 2; c < 10; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early c=%0d valid=%b timeout=%b want 0 0", c, rsp_valid, timeout);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b1 ||
        timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rsp valid=%b rdata=%h err=%b timeout=%b want 1 deadbeef 1 1",
               rsp_valid, rsp_rdata, rsp_err, timeout);
    end
    rsp_ready   = 1'b1;
    per_r_valid = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (spurious !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_late spurious=%b valid=%b busy=%b want 1 0 0", spurious, rsp_valid, busy);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_credit_stall();
    test_spurious();
    test_reset_midop();
`ifdef PERIPH_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
